// File: rtl/saw_square_osc.sv
// rtl/saw_square_osc.sv - square and rising sawtooth oscillator sharing one phase counter
// The saw slope comes from a serial divider so a new period never needs a combinational divide.
module saw_square_osc #(
  parameter int WIDTH     = 32,
  parameter int AMPLITUDE = 2**20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] wave_length_integer,
  output logic [WIDTH-1:0] square_value,
  output logic [WIDTH-1:0] saw_value
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0]        AMP       = WIDTH'(AMPLITUDE);
  localparam logic [WIDTH-1:0]        NEG_AMP   = WIDTH'(-AMPLITUDE);
  localparam logic [WIDTH-1:0]        DIVIDEND  = WIDTH'(2 * AMPLITUDE);
  localparam logic signed [WIDTH:0]   SAT_MAX   = (WIDTH+1)'(AMPLITUDE - 1);
  localparam logic [CW-1:0]           LAST_STEP = CW'(WIDTH - 1);

  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] nl;
  logic [WIDTH-1:0] den;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   rem;
  logic             busy;
  logic [CW-1:0]    cnt;

  logic                    run;
  logic                    wrap;
  logic [WIDTH-1:0]        half;
  logic signed [WIDTH:0]   saw_sum;
  logic [WIDTH-1:0]        saw_next;
  logic [WIDTH:0]          rem_sh;
  logic                    fits;
  logic [WIDTH:0]          rem_nx;
  logic [WIDTH-1:0]        quo_nx;

  assign run  = wave_length_integer >= WIDTH'(2);
  assign half = wave_length_integer >> 1;
  assign wrap = phase >= (wave_length_integer - WIDTH'(1));

  // Saw sum is one bit wider so an overshoot clamps instead of wrapping negative.
  assign saw_sum  = $signed({saw_value[WIDTH-1], saw_value}) + $signed({1'b0, inc});
  assign saw_next = (saw_sum > SAT_MAX) ? SAT_MAX[WIDTH-1:0] : saw_sum[WIDTH-1:0];

  assign rem_sh = {rem[WIDTH-1:0], num[WIDTH-1]};
  assign fits   = rem_sh >= {1'b0, den};
  assign rem_nx = fits ? (rem_sh - {1'b0, den}) : rem_sh;
  assign quo_nx = {quo[WIDTH-2:0], fits};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase        <= '0;
      square_value <= '0;
      saw_value    <= '0;
    end else if (!run) begin
      phase        <= '0;
      square_value <= '0;
      saw_value    <= '0;
    end else begin
      phase        <= wrap ? '0 : phase + WIDTH'(1);
      square_value <= (phase < half) ? AMP : NEG_AMP;
      saw_value    <= (phase == '0) ? NEG_AMP : saw_next;
    end
  end

  // Restoring divider for inc = 2*AMPLITUDE / N; any change of N mid-division abandons it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      den  <= '0;
      num  <= '0;
      rem  <= '0;
      quo  <= '0;
      inc  <= '0;
      nl   <= '0;
    end else if (busy) begin
      if (wave_length_integer != den) begin
        busy <= 1'b0;
      end else begin
        rem <= rem_nx;
        quo <= quo_nx;
        num <= num << 1;
        cnt <= cnt + CW'(1);
        if (cnt == LAST_STEP) begin
          busy <= 1'b0;
          inc  <= quo_nx;
          nl   <= den;
        end
      end
    end else if (run && (wave_length_integer != nl)) begin
      busy <= 1'b1;
      den  <= wave_length_integer;
      num  <= DIVIDEND;
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
    end
  end

endmodule

// File: tb/tb_saw_square_osc.sv
// tb/tb_saw_square_osc.sv - bench for saw_square_osc: vector table, corner sequences, random run vs model
module tb_saw_square_osc;

  localparam longint A = 1048576;
  localparam int     W = 32;

  logic          clk;
  logic          reset_n;
  logic [31:0]   n;
  logic [31:0]   square_value;
  logic [31:0]   saw_value;

  int checks = 0;
  int errors = 0;

  longint m_p, m_sq, m_saw, m_inc, m_nl, m_cap;
  int     m_cnt;
  bit     m_busy;

  saw_square_osc #(.WIDTH(32), .AMPLITUDE(2**20)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .wave_length_integer (n),
    .square_value        (square_value),
    .saw_value           (saw_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int idx;
    int sq;
    int saw;
  } vec_t;
  vec_t vecs[$];

  function automatic longint sq_now();
    return longint'($signed(square_value));
  endfunction

  function automatic longint saw_now();
    return longint'($signed(saw_value));
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_sq = 0; m_saw = 0; m_inc = 0; m_nl = 0; m_cap = 0;
    m_cnt = 0; m_busy = 0;
  endtask

  // Advance one clock: predict from the pre-edge state, then compare just after the edge.
  task automatic tick();
    longint nv, np, nsq, nsaw, ninc, nnl, ncap;
    int     ncnt;
    bit     nbusy;
    nv = longint'(n);
    np = m_p; nsq = m_sq; nsaw = m_saw; ninc = m_inc; nnl = m_nl; ncap = m_cap;
    ncnt = m_cnt; nbusy = m_busy;
    if (nv < 2) begin
      np = 0; nsq = 0; nsaw = 0;
    end else begin
      np   = (m_p >= nv - 1) ? 0 : m_p + 1;
      nsq  = (m_p < nv / 2) ? A : -A;
      if (m_p == 0) nsaw = -A;
      else begin
        nsaw = m_saw + m_inc;
        if (nsaw > A - 1) nsaw = A - 1;
      end
    end
    if (m_busy) begin
      if (nv != m_cap) nbusy = 0;
      else begin
        ncnt = m_cnt + 1;
        if (ncnt == W) begin
          ninc  = (2 * A) / m_cap;
          nnl   = m_cap;
          nbusy = 0;
        end
      end
    end else if (nv >= 2 && nv != m_nl) begin
      nbusy = 1; ncap = nv; ncnt = 0;
    end
    @(posedge clk);
    #1;
    if (!reset_n) model_reset();
    else begin
      m_p = np; m_sq = nsq; m_saw = nsaw; m_inc = ninc; m_nl = nnl; m_cap = ncap;
      m_cnt = ncnt; m_busy = nbusy;
    end
    check("model_square", sq_now(), m_sq);
    check("model_saw", saw_now(), m_saw);
  endtask

  task automatic align();
    bit found;
    found = (saw_now() == -A);
    for (int k = 0; k < 64 && !found; k++) begin
      tick();
      found = (saw_now() == -A);
    end
    check("align_timeout", longint'(found), 1);
  endtask

  initial begin
    vecs.push_back('{8, 0,  1048576, -1048576});
    vecs.push_back('{8, 1,  1048576,  -786432});
    vecs.push_back('{8, 2,  1048576,  -524288});
    vecs.push_back('{8, 3,  1048576,  -262144});
    vecs.push_back('{8, 4, -1048576,        0});
    vecs.push_back('{8, 5, -1048576,   262144});
    vecs.push_back('{8, 6, -1048576,   524288});
    vecs.push_back('{8, 7, -1048576,   786432});
    vecs.push_back('{3, 0,  1048576, -1048576});
    vecs.push_back('{3, 1, -1048576,  -349526});
    vecs.push_back('{3, 2, -1048576,   349524});
    vecs.push_back('{2, 0,  1048576, -1048576});
    vecs.push_back('{2, 1, -1048576,        0});

    model_reset();
    reset_n = 1'b0;
    n = 32'd8;
    tick();
    tick();
    check("reset_square", sq_now(), 0);
    check("reset_saw", saw_now(), 0);
    reset_n = 1'b1;
    tick();
    check("first_edge_square", sq_now(), A);
    check("first_edge_saw", saw_now(), -A);

    // Asynchronous reset in the middle of a running waveform.
    repeat (5) tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_square", sq_now(), 0);
    check("async_reset_saw", saw_now(), 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("release_square", sq_now(), A);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].idx == 0) begin
        n = vecs[i].n;
        repeat (40) tick();
        align();
      end else begin
        tick();
      end
      check($sformatf("vec%0d_n%0d_square", i, vecs[i].n), sq_now(), vecs[i].sq);
      check($sformatf("vec%0d_n%0d_saw", i, vecs[i].n), saw_now(), vecs[i].saw);
    end

    for (int m = 0; m < 2; m++) begin
      n = m;
      repeat (3) tick();
      check($sformatf("mute_n%0d_square", m), sq_now(), 0);
      check($sformatf("mute_n%0d_saw", m), saw_now(), 0);
    end

    // Period drop 8 -> 4 at phase 6, stale increment until the divider finishes.
    n = 32'd8;
    repeat (40) tick();
    align();
    repeat (5) tick();
    check("drop_pre_saw", saw_now(), 262144);
    n = 32'd4;
    tick();
    check("drop_wrap_saw", saw_now(), 524288);
    tick();
    check("drop_restart_saw", saw_now(), -A);
    tick();
    check("drop_stale_inc_saw", saw_now(), -786432);
    for (int k = 0; k < 40; k++) begin
      tick();
      check("drop_saw_max", longint'(saw_now() > A - 1), 0);
    end
    align();
    for (int k = 1; k < 4; k++) begin
      tick();
      check($sformatf("drop_new_inc_saw%0d", k), saw_now(), -A + k * 524288);
    end

    // Period rise 2 -> 8 with the large stale increment must clamp.
    n = 32'd2;
    repeat (40) tick();
    align();
    n = 32'd8;
    tick();
    check("rise_saw0", saw_now(), 0);
    tick();
    check("rise_saw_sat", saw_now(), A - 1);

    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r == 0) n = $urandom_range(0, 1);
      else if (r == 1 || r == 2) n = $urandom_range(2, 40);
      else if (r == 3) n = $urandom_range(2, 2000);
      else if (r == 4 && $urandom_range(0, 9) == 0) n = $urandom;
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0;
        model_reset();
      end else begin
        reset_n = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
